uart_tx: RTL and testbench

- Serial transmit side of the Bluetooth-module UART link; the outbound counterpart of the existing receiver path.
- Accepts one byte per valid/ready handshake and shifts it out LSB-first as an 8N1 frame (configurable stop bits, optional parity).
- Bit timing comes from an internal baud counter running on the system clock. No divided clock is generated; all logic runs on clk.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_baud_tick.sv | 45 ++++
 rtl/uart_tx.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Definitions shared by the UART transmit and receive paths.
//            - frame state encoding
//            - data width
//            - default baud divisor (50 MHz / 9600 baud)
//            - even-parity helper
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_W               = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 5208;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module   : uart_baud_tick
// Purpose  : Baud-rate counter on the system clock. The counter runs
//            0..CLKS_PER_BIT-1 and tick pulses for one cycle at the final
//            count, so consecutive ticks are CLKS_PER_BIT cycles apart.
//            Asserting clr holds the counter at 0.
// Ports    : clk   - system clock
//            rst_n - synchronous active-low reset
//            clr   - hold/restart the counter at 0
//            tick  - one-cycle pulse at the last count of a bit period
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmitter. Takes one byte per valid/ready handshake and
//            sends it LSB-first as start + 8 data + [parity] + stop bits.
//            Every output comes from a register.
// Config   : `define UART_TX_PARITY_EN to add an even-parity bit after the
//            data bits. When it is not defined, no parity bit is sent.
// Ports    : clk      - system clock
//            rst_n    - synchronous active-low reset
//            tx_data  - byte to send, sampled on handshake only
//            tx_valid - producer has a byte
//            tx_ready - block can accept a byte (registered)
//            tx       - serial line, idles high
//            tx_busy  - a frame is on the line
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy
);

    // Value the stop-bit counter holds during the final stop bit.
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_t       r_state,    w_state_nxt;
    logic [DATA_W-1:0] r_shift,    w_shift_nxt;
    logic [2:0]        r_bit_cnt,  w_bit_cnt_nxt;
    logic              r_stop_cnt, w_stop_cnt_nxt;
    logic              r_tx,       w_tx_nxt;
    logic              r_ready,    w_ready_nxt;
    logic              r_busy,     w_busy_nxt;
    logic              w_tick;
    logic              w_baud_clr;
`ifdef UART_TX_PARITY_EN
    logic              r_parity,   w_parity_nxt;
`endif

    // The baud counter stays at 0 while idle, so the start bit lasts a full
    // bit period counted from the accept edge.
    assign w_baud_clr = (r_state == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_baud_clr),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_tx       <= w_tx_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity   <= w_parity_nxt;
`endif
        end
    end

    // Next-state logic also computes the next value of each registered
    // output. That way tx changes on the same edge as the state does.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_tx_nxt       = r_tx;
        w_ready_nxt    = r_ready;
        w_busy_nxt     = r_busy;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt   = r_parity;
`endif

        case (r_state)
            IDLE: begin
                w_tx_nxt    = 1'b1;
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                if (tx_valid && r_ready) begin
                    w_shift_nxt   = tx_data;
                    w_bit_cnt_nxt = 3'd0;
                    w_state_nxt   = START;
                    w_tx_nxt      = 1'b0;
                    w_ready_nxt   = 1'b0;
                    w_busy_nxt    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    // Parity is computed from the byte as it is latched,
                    // because the shift register is consumed during DATA.
                    w_parity_nxt  = even_parity(tx_data);
`endif
                end
            end

            START: begin
                if (w_tick) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end

            DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == 3'd7) begin
                        // The frame leaves DATA at count 7, so the bit
                        // counter never wraps.
`ifdef UART_TX_PARITY_EN
                        w_state_nxt    = PARITY;
                        w_tx_nxt       = r_parity;
`else
                        w_state_nxt    = STOP;
                        w_tx_nxt       = 1'b1;
                        w_stop_cnt_nxt = 1'b0;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        w_tx_nxt      = w_shift_nxt[0];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_state_nxt    = STOP;
                    w_tx_nxt       = 1'b1;
                    w_stop_cnt_nxt = 1'b0;
                end
            end
`endif

            STOP: begin
                if (w_tick) begin
                    if (r_stop_cnt == STOP_LAST) begin
                        // Ready rises in the first IDLE cycle. A producer
                        // holding tx_valid is accepted at the end of that
                        // cycle, which leaves one idle-high clock.
                        w_state_nxt = IDLE;
                        w_tx_nxt    = 1'b1;
                        w_ready_nxt = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign tx       = r_tx;
    assign tx_ready = r_ready;
    assign tx_busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. It uses two instances, one
//            with STOP_BITS=1 and one with STOP_BITS=2, and CLKS_PER_BIT=16.
//            The expected line waveform is built from the frame definition
//            (start, data LSB-first, optional parity, stop bits). The bench
//            also decodes each frame by sampling at the middle of each bit.
// Config   : honours UART_TX_PARITY_EN in the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       valid1, valid2;
    wire        ready1, tx1, busy1;
    wire        ready2, tx2, busy2;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid1),
        .tx_ready(ready1), .tx(tx1), .tx_busy(busy1)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid2),
        .tx_ready(ready2), .tx(tx2), .tx_busy(busy2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc1[$];
    int acc2[$];

    // Record the clock cycle of every accept, for period checks.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n === 1'b1 && valid1 === 1'b1 && ready1 === 1'b1) acc1.push_back(cyc);
        if (rst_n === 1'b1 && valid2 === 1'b1 && ready2 === 1'b1) acc2.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_tx(input int sel);
        return (sel == 2) ? tx2 : tx1;
    endfunction
    function automatic logic cur_ready(input int sel);
        return (sel == 2) ? ready2 : ready1;
    endfunction
    function automatic logic cur_busy(input int sel);
        return (sel == 2) ? busy2 : busy1;
    endfunction

    // Send one byte on the selected instance and check the full frame.
    // When hold is 1, valid stays high after the accept, so the next call
    // exercises a back-to-back accept.
    task automatic send_frame(input int sel, input logic [7:0] d, input bit hold);
        int   sb, nbits, len, n, wave_bad, rdy_bad, busy_bad, first_bad;
        logic exp_bits[0:15];
        logic cap[$];
        logic [7:0] dec;

        sb    = (sel == 2) ? 2 : 1;
        nbits = 1 + 8 + P + sb;
        len   = nbits * CPB;

        // Reference frame: one level per bit slot.
        for (int i = 0; i < 16; i++) exp_bits[i] = 1'b1;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
        exp_bits[9] = ^d;
`endif

        n = 0;
        while (cur_ready(sel) !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, cur_ready(sel)}, 32'd1);

        tx_data = d;
        if (sel == 2) valid2 = 1'b1; else valid1 = 1'b1;
        @(posedge clk);
        #1;
        if (sel == 2) valid2 = hold; else valid1 = hold;
        tx_data = ~d;   // ignored while a frame is in flight

        wave_bad = 0; rdy_bad = 0; busy_bad = 0; first_bad = -1;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            cap.push_back(cur_tx(sel));
            if (cur_tx(sel) !== exp_bits[c / CPB]) begin
                wave_bad++;
                if (first_bad < 0) first_bad = c;
            end
            if (cur_ready(sel) !== 1'b0) rdy_bad++;
            if (cur_busy(sel)  !== 1'b1) busy_bad++;
        end
        chk($sformatf("wave_%0d_%02h(first_bad=%0d)", sel, d, first_bad), wave_bad, 0);
        chk($sformatf("ready_low_%0d_%02h", sel, d), rdy_bad, 0);
        chk($sformatf("busy_high_%0d_%02h", sel, d), busy_bad, 0);

        // Receiver model: sample each bit at its middle.
        for (int i = 0; i < 8; i++) dec[i] = cap[(1 + i) * CPB + CPB / 2];
        chk($sformatf("start_%0d_%02h", sel, d), {31'd0, cap[CPB / 2]}, 32'd0);
        chk($sformatf("decode_%0d", sel), {24'd0, dec}, {24'd0, d});
`ifdef UART_TX_PARITY_EN
        chk($sformatf("parity_%02h", d), {31'd0, cap[9 * CPB + CPB / 2]}, {31'd0, ^d});
`endif
        chk($sformatf("stop_%0d_%02h", sel, d), {31'd0, cap[(nbits - 1) * CPB + CPB / 2]}, 32'd1);

        // Ready should return exactly len clocks after the accept.
        @(negedge clk);
        chk($sformatf("ready_end_%0d_%02h", sel, d), {31'd0, cur_ready(sel)}, 32'd1);
        chk($sformatf("busy_end_%0d_%02h", sel, d),  {31'd0, cur_busy(sel)},  32'd0);
        chk($sformatf("tx_idle_%0d_%02h", sel, d),   {31'd0, cur_tx(sel)},    32'd1);
    endtask

    initial begin
        int sel;
        rst_n   = 1'b0;
        valid1  = 1'b0;
        valid2  = 1'b0;
        tx_data = 8'h00;

        // Reset held for three clocks: the line stays idle-high throughout.
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx1",    {31'd0, tx1},    32'd1);
            chk("rst_ready1", {31'd0, ready1}, 32'd1);
            chk("rst_busy1",  {31'd0, busy1},  32'd0);
            chk("rst_tx2",    {31'd0, tx2},    32'd1);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_tx1", {31'd0, tx1}, 32'd1);

        // Single byte on a one-stop-bit frame.
        send_frame(1, 8'h55, 1'b0);

        // Back-to-back with valid held high.
        send_frame(1, 8'hA5, 1'b1);
        send_frame(1, 8'h3C, 1'b0);
        chk("b2b_period", acc1[$] - acc1[$-1], (1 + 8 + P + 1) * CPB + 1);

        // Two stop bits, all-zero data.
        send_frame(2, 8'h00, 1'b0);

        // Parity patterns, sent back-to-back to check the frame period.
        send_frame(1, 8'h07, 1'b1);
        send_frame(1, 8'h03, 1'b0);
        chk("parity_period", acc1[$] - acc1[$-1], (1 + 8 + P + 1) * CPB + 1);

        // Two-stop back-to-back period.
        send_frame(2, 8'h81, 1'b1);
        send_frame(2, 8'h7E, 1'b0);
        chk("stop2_period", acc2[$] - acc2[$-1], (1 + 8 + P + 2) * CPB + 1);

        // Reset while data bit 4 of 0xF0 is on the line.
        @(negedge clk);
        tx_data = 8'hF0;
        valid1  = 1'b1;
        @(posedge clk);
        #1;
        valid1 = 1'b0;
        repeat (4 * CPB + 9) @(negedge clk);
        chk("mid_bit3", {31'd0, tx1}, 32'd0);
        repeat (CPB) @(negedge clk);
        chk("mid_bit4", {31'd0, tx1}, 32'd1);
        chk("mid_busy", {31'd0, busy1}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_tx",    {31'd0, tx1},    32'd1);
        chk("mrst_ready", {31'd0, ready1}, 32'd1);
        chk("mrst_busy",  {31'd0, busy1},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(1, 8'h0F, 1'b0);

        // Randomised bursts of two frames on a randomly chosen instance.
        for (int g = 0; g < 6; g++) begin
            sel = int'($urandom_range(1, 2));
            send_frame(sel, 8'($urandom), 1'b1);
            send_frame(sel, 8'($urandom), 1'b0);
            if (sel == 1)
                chk("rand_period1", acc1[$] - acc1[$-1], (1 + 8 + P + 1) * CPB + 1);
            else
                chk("rand_period2", acc2[$] - acc2[$-1], (1 + 8 + P + 2) * CPB + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
